// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry and display block.
// Key codes, key FSM states, keypad and 7-segment decoders.
package keypad_pkg;

  localparam logic [3:0] KEY_BKSP = 4'hA;
  localparam logic [3:0] KEY_CLR  = 4'hB;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAND = 2'd1,
    ST_HELD = 2'd2
  } key_st_e;

  function automatic logic [3:0] key_decode(
    input logic [2:0] s,
    input logic [2:0] col
  );
    logic [1:0] k;
    logic       hit;
    hit = 1'b1;
    k   = 2'd0;
    unique case (1'b1)
      (col == 3'b011): k = 2'd0;
      (col == 3'b101): k = 2'd1;
      (col == 3'b110): k = 2'd2;
      default:         hit = 1'b0;
    endcase
    key_decode = KEY_NONE;
    if (hit) begin
      unique case (s)
        3'd0: key_decode = 4'd1 + {2'b00, k};
        3'd1: key_decode = 4'd4 + {2'b00, k};
        3'd2: key_decode = 4'd7 + {2'b00, k};
        3'd3: begin
          unique case (k)
            2'd0:    key_decode = KEY_BKSP;
            2'd1:    key_decode = 4'd0;
            default: key_decode = KEY_CLR;
          endcase
        end
        default: key_decode = KEY_NONE;
      endcase
    end
  endfunction

  function automatic logic [6:0] seg7_decode(
    input logic [3:0] d
  );
    case (d)
      4'd0:    seg7_decode = 7'b1111110;
      4'd1:    seg7_decode = 7'b0110000;
      4'd2:    seg7_decode = 7'b1101101;
      4'd3:    seg7_decode = 7'b1111001;
      4'd4:    seg7_decode = 7'b0110011;
      4'd5:    seg7_decode = 7'b1011011;
      4'd6:    seg7_decode = 7'b1011111;
      4'd7:    seg7_decode = 7'b1110000;
      4'd8:    seg7_decode = 7'b1111111;
      4'd9:    seg7_decode = 7'b1111011;
      default: seg7_decode = 7'b0000000;
    endcase
  endfunction

endpackage

// File: rtl/keypad_entry_display_font.sv
// 8x8 glyphs for digits 0-9; anything else is blank.
// Row index 0 is the top row of the matrix.
module digit_font_rom
  import keypad_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [2:0] row_idx,
  output logic [7:0] pattern
);

  logic [63:0] glyph;
  logic [5:0]  base;

  // Glyph lookup, top row held in the most significant byte
  always_comb begin
    case (digit)
      4'd0:    glyph = 64'h3C666E7666663C00;
      4'd1:    glyph = 64'h0818080808081C00;
      4'd2:    glyph = 64'h3C66060C30607E00;
      4'd3:    glyph = 64'h3C66061C06663C00;
      4'd4:    glyph = 64'h0C1C2C4C7E0C0C00;
      4'd5:    glyph = 64'h7E607C0606663C00;
      4'd6:    glyph = 64'h1C30607C66663C00;
      4'd7:    glyph = 64'h7E060C1830303000;
      4'd8:    glyph = 64'h3C66663C66663C00;
      4'd9:    glyph = 64'h3C66663E060C3800;
      default: glyph = 64'h0;
    endcase
    base    = {3'd7 - row_idx, 3'b000};
    pattern = glyph[base +: 8];
  end

endmodule

// File: rtl/keypad_entry_display.sv
// Keypad scan, per-frame debounce, digit buffer and display mux.
// Drives the shared 7-seg/keypad select and the 8x8 red matrix.
module keypad_entry_display
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DIV_EXP    = 13,
  parameter int DEB_FRAMES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] column,
  output logic [2:0] sel,
  output logic [6:0] seg7,
  output logic [7:0] row,
  output logic [7:0] column_red,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit_count
);

  localparam logic [2:0] SEL_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [3:0] DEB_N    = 4'(DEB_FRAMES);
  localparam logic [3:0] DIG_MAX  = 4'(NUM_DIGITS);

  logic [DIV_EXP-1:0] presc_q, presc_d;
  logic [2:0]         col_s1_q, col_s2_q;
  logic [2:0]         sel_q, sel_d;
  logic [3:0]         facc_q, facc_d;
  key_st_e            st_q, st_d;
  logic [3:0]         cand_q, cand_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               kv_q, kv_d;
  logic [3:0]         kc_q, kc_d;
  logic [3:0]         dcnt_q, dcnt_d;
  logic [NUM_DIGITS-1:0][3:0] dbuf_q, dbuf_d;
  logic [7:0]         row_q, row_d;
  logic [2:0]         ridx_q, ridx_d;
  logic [7:0]         colr_q, colr_d;

  logic       tick;
  logic       frame_end;
  logic [3:0] samp;
  logic [3:0] frame_code;
  logic       acc;
  logic [3:0] acc_code;
  logic [3:0] cur_digit;
  logic [7:0] font_row;

  assign tick      = &presc_q;
  assign frame_end = tick && (sel_q == SEL_LAST);
  assign samp      = key_decode(sel_q, col_s2_q);

  // Prescaler and scan select advance
  always_comb begin
    presc_d = presc_q + 1'b1;
    sel_d   = sel_q;
    if (tick) begin
      sel_d = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
    end
  end

  // Frame capture: the lowest select with a valid key wins
  always_comb begin
    frame_code = (facc_q != KEY_NONE) ? facc_q : samp;
    facc_d     = facc_q;
    if (tick) begin
      if (frame_end) begin
        facc_d = KEY_NONE;
      end else if (facc_q == KEY_NONE) begin
        facc_d = samp;
      end
    end
  end

  // Key FSM next state, evaluated once per frame
  always_comb begin
    st_d     = st_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    acc      = 1'b0;
    acc_code = cand_q;
    if (frame_end) begin
      unique case (st_q)
        ST_IDLE: begin
          if (frame_code != KEY_NONE) begin
            cand_d = frame_code;
            if (DEB_N == 4'd1) begin
              acc      = 1'b1;
              acc_code = frame_code;
              st_d     = ST_HELD;
              cnt_d    = 4'd0;
            end else begin
              st_d  = ST_CAND;
              cnt_d = 4'd1;
            end
          end
        end
        ST_CAND: begin
          if (frame_code == cand_q) begin
            if (cnt_q + 4'd1 >= DEB_N) begin
              acc   = 1'b1;
              st_d  = ST_HELD;
              cnt_d = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            st_d  = ST_IDLE;
            cnt_d = 4'd0;
          end
        end
        ST_HELD: begin
          if (frame_code == KEY_NONE) begin
            if (cnt_q + 4'd1 >= DEB_N) begin
              st_d  = ST_IDLE;
              cnt_d = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        default: begin
          st_d  = ST_IDLE;
          cnt_d = 4'd0;
        end
      endcase
    end
  end

  // Digit buffer edit on an accepted key
  always_comb begin
    dbuf_d = dbuf_q;
    dcnt_d = dcnt_q;
    kv_d   = acc;
    kc_d   = kc_q;
    if (acc) begin
      kc_d = acc_code;
      unique case (1'b1)
        (acc_code <= 4'd9): begin
          for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            dbuf_d[i] = dbuf_q[i+1];
          end
          dbuf_d[NUM_DIGITS-1] = acc_code;
          if (dcnt_q != DIG_MAX) begin
            dcnt_d = dcnt_q + 4'd1;
          end
        end
        (acc_code == KEY_BKSP): begin
          if (dcnt_q != 4'd0) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
              dbuf_d[i] = dbuf_q[i-1];
            end
            dbuf_d[0] = KEY_NONE;
            dcnt_d    = dcnt_q - 4'd1;
          end
        end
        (acc_code == KEY_CLR): begin
          dbuf_d = '1;
          dcnt_d = 4'd0;
        end
        default: ;
      endcase
    end
  end

  // Digit under the current select for the 7-seg bank
  always_comb begin
    cur_digit = KEY_NONE;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_q == 3'(i)) begin
        cur_digit = dbuf_q[i];
      end
    end
  end

  digit_font_rom u_font (
    .digit   (dbuf_q[NUM_DIGITS-1]),
    .row_idx (ridx_q + 3'd1),
    .pattern (font_row)
  );

  // Matrix row rotation with column data kept aligned
  always_comb begin
    row_d  = row_q;
    ridx_d = ridx_q;
    colr_d = colr_q;
    if (tick) begin
      row_d  = {row_q[0], row_q[7:1]};
      ridx_d = ridx_q + 3'd1;
      colr_d = font_row;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q  <= '0;
      col_s1_q <= 3'b111;
      col_s2_q <= 3'b111;
      sel_q    <= 3'd0;
      facc_q   <= KEY_NONE;
      st_q     <= ST_IDLE;
      cand_q   <= KEY_NONE;
      cnt_q    <= 4'd0;
      kv_q     <= 1'b0;
      kc_q     <= KEY_NONE;
      dcnt_q   <= 4'd0;
      dbuf_q   <= '1;
      row_q    <= 8'b1000_0000;
      ridx_q   <= 3'd0;
      colr_q   <= 8'h00;
    end else begin
      presc_q  <= presc_d;
      col_s1_q <= column;
      col_s2_q <= col_s1_q;
      sel_q    <= sel_d;
      facc_q   <= facc_d;
      st_q     <= st_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      kv_q     <= kv_d;
      kc_q     <= kc_d;
      dcnt_q   <= dcnt_d;
      dbuf_q   <= dbuf_d;
      row_q    <= row_d;
      ridx_q   <= ridx_d;
      colr_q   <= colr_d;
    end
  end

  assign sel         = sel_q;
  assign seg7        = seg7_decode(cur_digit);
  assign row         = row_q;
  assign column_red  = colr_q;
  assign key_valid   = kv_q;
  assign key_code    = kc_q;
  assign digit_count = dcnt_q;

endmodule

// File: tb/tb_keypad_entry_display.sv
// Directed bench for keypad_entry_display.
// Fast scan (DIV_EXP=3), six digits, three-frame debounce.
module tb_keypad_entry_display;

  localparam int FR = 48;

  logic       clk;
  logic       reset;
  logic [2:0] column;
  logic [2:0] sel;
  logic [6:0] seg7;
  logic [7:0] row;
  logic [7:0] column_red;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] digit_count;

  int          checks;
  int          errors;
  int          kv_count;
  int          p_sel;
  logic [2:0]  p_col;
  int          kv0;
  logic [7:0]  g1 [8];

  keypad_entry_display #(
    .NUM_DIGITS (6),
    .DIV_EXP    (3),
    .DEB_FRAMES (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .column      (column),
    .sel         (sel),
    .seg7        (seg7),
    .row         (row),
    .column_red  (column_red),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .digit_count (digit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign column = (p_sel >= 0 && int'(sel) == p_sel) ? p_col : 3'b111;

  always @(negedge clk) begin
    if (key_valid === 1'b1) kv_count++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic wait_sel(input int k);
    int n;
    n = 0;
    while (int'(sel) != k && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_sel", 32'(sel), 32'(k));
  endtask

  task automatic check_digits(input string tag, input logic [23:0] d);
    for (int k = 0; k < 6; k++) begin
      wait_sel(k);
      chk(tag, 32'(seg7), 32'(seg_of(d[(5-k)*4 +: 4])));
    end
  endtask

  task automatic press(input int s, input logic [2:0] c,
                       input int hold, input int rel);
    p_sel = s;
    p_col = c;
    repeat (FR * hold) @(negedge clk);
    p_sel = -1;
    repeat (FR * rel) @(negedge clk);
  endtask

  task automatic wait_row(input logic [7:0] r);
    int n;
    n = 0;
    while (row !== r && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_row", 32'(row), 32'(r));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    kv_count = 0;
    p_sel    = -1;
    p_col    = 3'b111;
    g1 = '{8'h08, 8'h18, 8'h08, 8'h08, 8'h08, 8'h08, 8'h1C, 8'h00};
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_row", 32'(row), 32'h80);
    chk("rst_colr", 32'(column_red), 32'h00);
    chk("rst_kv", 32'(key_valid), 32'd0);
    chk("rst_kc", 32'(key_code), 32'hF);
    chk("rst_cnt", 32'(digit_count), 32'd0);
    chk("rst_seg", 32'(seg7), 32'd0);
    reset = 1'b1;
    repeat (7) @(negedge clk);
    chk("row_hold", 32'(row), 32'h80);
    @(negedge clk);
    chk("row_rot", 32'(row), 32'h40);
    chk("sel_inc", 32'(sel), 32'd1);
    check_digits("seg_blank", 24'hFFFFFF);

    kv0 = kv_count;
    press(0, 3'b011, 4, 5);
    chk("one_kv", 32'(kv_count - kv0), 32'd1);
    chk("one_kc", 32'(key_code), 32'd1);
    chk("one_cnt", 32'(digit_count), 32'd1);
    check_digits("seg_one", 24'hFFFFF1);
    wait_row(8'h01);
    wait_row(8'h80);
    for (int r = 0; r < 8; r++) begin
      chk("mx_row", 32'(row), 32'(8'h80 >> r));
      chk("mx_col", 32'(column_red), 32'(g1[r]));
      repeat (8) @(negedge clk);
    end

    kv0 = kv_count;
    press(0, 3'b101, 4, 4);
    press(0, 3'b110, 4, 4);
    press(1, 3'b011, 4, 4);
    press(1, 3'b101, 4, 4);
    press(1, 3'b110, 4, 4);
    press(2, 3'b011, 4, 4);
    chk("seq_kv", 32'(kv_count - kv0), 32'd6);
    chk("seq_kc", 32'(key_code), 32'd7);
    chk("seq_cnt", 32'(digit_count), 32'd6);
    check_digits("seg_seq", 24'h234567);

    press(3, 3'b011, 4, 4);
    chk("bs1_kc", 32'(key_code), 32'hA);
    chk("bs1_cnt", 32'(digit_count), 32'd5);
    check_digits("seg_bs1", 24'hF23456);
    press(3, 3'b011, 4, 4);
    chk("bs2_cnt", 32'(digit_count), 32'd4);
    check_digits("seg_bs2", 24'hFF2345);
    press(3, 3'b110, 4, 4);
    chk("clr_kc", 32'(key_code), 32'hB);
    chk("clr_cnt", 32'(digit_count), 32'd0);
    check_digits("seg_clr", 24'hFFFFFF);
    kv0 = kv_count;
    press(3, 3'b011, 4, 4);
    chk("bs0_kv", 32'(kv_count - kv0), 32'd1);
    chk("bs0_kc", 32'(key_code), 32'hA);
    chk("bs0_cnt", 32'(digit_count), 32'd0);
    check_digits("seg_bs0", 24'hFFFFFF);

    kv0 = kv_count;
    for (int i = 0; i < 6; i++) press(0, 3'b011, 1, 1);
    repeat (FR * 4) @(negedge clk);
    chk("bounce_kv", 32'(kv_count - kv0), 32'd0);
    chk("bounce_cnt", 32'(digit_count), 32'd0);

    kv0 = kv_count;
    press(2, 3'b110, 100, 5);
    chk("hold_kv", 32'(kv_count - kv0), 32'd1);
    chk("hold_kc", 32'(key_code), 32'd9);
    chk("hold_cnt", 32'(digit_count), 32'd1);

    p_sel = 1;
    p_col = 3'b101;
    repeat (FR + FR / 2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_cnt", 32'(digit_count), 32'd0);
    chk("arst_kc", 32'(key_code), 32'hF);
    chk("arst_row", 32'(row), 32'h80);
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_kv", 32'(key_valid), 32'd0);
    p_sel = -1;
    kv0 = kv_count;
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (FR * 5) @(negedge clk);
    chk("cand_kv", 32'(kv_count - kv0), 32'd0);
    chk("cand_cnt", 32'(digit_count), 32'd0);

    kv0 = kv_count;
    p_sel = 2;
    p_col = 3'b101;
    repeat (FR * 5) @(negedge clk);
    chk("held_kv", 32'(kv_count - kv0), 32'd1);
    chk("held_kc", 32'(key_code), 32'd8);
    #2 reset = 1'b0;
    #1;
    chk("hrst_cnt", 32'(digit_count), 32'd0);
    chk("hrst_kc", 32'(key_code), 32'hF);
    chk("hrst_colr", 32'(column_red), 32'h00);
    p_sel = -1;
    kv0 = kv_count;
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (FR * 5) @(negedge clk);
    chk("hrel_kv", 32'(kv_count - kv0), 32'd0);
    press(0, 3'b110, 4, 5);
    chk("fresh_kv", 32'(kv_count - kv0), 32'd1);
    chk("fresh_kc", 32'(key_code), 32'd3);
    chk("fresh_cnt", 32'(digit_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
